// File: rtl/fft_frame_buffer_if.sv
// ---------------------------------------------------------------------------
// fft_frame_buffer_if
//
// Sample stream from the frame buffer to the FFT core.
//
// Signals:
//   sample_out    signed sample, BIT_WIDTH bits      (master -> slave)
//   sample_valid  sample_out holds a valid sample    (master -> slave)
//   sample_last   marks the final sample of a frame  (master -> slave)
//   sample_ready  FFT accepts the presented sample   (slave  -> master)
//
// A transfer happens on every clk edge where sample_valid && sample_ready.
// BIT_WIDTH must match the BIT_WIDTH of the fft_frame_buffer instance.
// ---------------------------------------------------------------------------
interface fft_frame_buffer_if #(
    parameter int BIT_WIDTH = 16
);
    logic signed [BIT_WIDTH-1:0] sample_out;
    logic                        sample_valid;
    logic                        sample_last;
    logic                        sample_ready;

    modport master (
        output sample_out,
        output sample_valid,
        output sample_last,
        input  sample_ready
    );

    modport slave (
        input  sample_out,
        input  sample_valid,
        input  sample_last,
        output sample_ready
    );
endinterface

// File: rtl/fft_frame_buffer.sv
// ---------------------------------------------------------------------------
// fft_frame_buffer
//
// Bridges 32-bit words from the SPI receiver (sclk domain) into clk, unpacks
// each word into two signed samples and collects FRAME_LEN samples per frame.
// Each complete frame is streamed to the FFT one sample per handshake.
//
// Ports:
//   clk          system clock (at least 4x the SPI sclk)
//   reset        synchronous, active-high
//   received_wd  word-complete flag from the SPI receiver (asynchronous here)
//   fft_in       received word; upper half is the earlier sample
//   smp          sample stream to the FFT (fft_frame_buffer_if.master)
//   overflow     sticky: a word arrived with no bank free to take it
//   frames_done  number of frames fully streamed, wraps at 255
//
// Build option:
//   FFT_FRAME_PINGPONG_EN  defined   -> two banks, fill one while the other
//                                       streams (write side alternates A,B,A..)
//                          undefined -> single bank; words arriving while the
//                                       bank is full or streaming are dropped
// ---------------------------------------------------------------------------
module fft_frame_buffer #(
    parameter int BIT_WIDTH = 16,
    parameter int FRAME_LEN = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     received_wd,
    input  logic [2*BIT_WIDTH-1:0]   fft_in,
    fft_frame_buffer_if.master       smp,
    output logic                     overflow,
    output logic [7:0]               frames_done
);

    localparam int HALF = FRAME_LEN / 2;
    localparam int WPW  = $clog2(HALF);
    localparam int IW   = $clog2(FRAME_LEN);
`ifdef FFT_FRAME_PINGPONG_EN
    localparam int NB   = 2;
`else
    localparam int NB   = 1;
`endif
    localparam int AW   = $clog2(NB * HALF);

    localparam logic [WPW-1:0] WP_LAST  = WPW'(HALF - 1);
    localparam logic [IW-1:0]  IDX_LAST = IW'(FRAME_LEN - 1);

    typedef enum logic { B_FILL, B_FULL }     bank_t;
    typedef enum logic { R_IDLE, R_STREAM }   rd_state_t;

    // -----------------------------------------------------------------------
    // received_wd synchroniser and rising-edge detector.
    // The stages reset to 1 so a flag already high at reset release does not
    // look like a fresh edge; a new word needs a fall and a rise.
    // -----------------------------------------------------------------------
    logic rwd_s1, rwd_s2, rwd_s3;
    logic word_stb;

    always_ff @(posedge clk) begin
        if (reset) begin
            rwd_s1   <= 1'b1;
            rwd_s2   <= 1'b1;
            rwd_s3   <= 1'b1;
            word_stb <= 1'b0;
        end else begin
            rwd_s1   <= received_wd;
            rwd_s2   <= rwd_s1;
            rwd_s3   <= rwd_s2;
            word_stb <= rwd_s2 & ~rwd_s3;
        end
    end

    // -----------------------------------------------------------------------
    // Bank bookkeeping
    // -----------------------------------------------------------------------
    bank_t           bank_q [NB];
    bank_t           bank_n [NB];
    logic [WPW-1:0]  wp_q, wp_n;
    logic            wr_fill;     // bank selected for writing is in FILL
    logic            rd_full;     // bank selected for reading is FULL
    logic            wr_en;
    logic            frame_release;
    logic            overflow_n;
    int unsigned     wsel, rsel;
    logic [AW-1:0]   waddr, raddr;

    rd_state_t                   rs_q, rs_n;
    logic [IW-1:0]               idx_q, idx_n, nxt_idx;
    logic signed [BIT_WIDTH-1:0] so_n;
    logic                        valid_n, last_n;
    logic [2*BIT_WIDTH-1:0]      rd_word;

`ifdef FFT_FRAME_PINGPONG_EN
    logic wbank_q, wbank_n;
    logic rbank_q, rbank_n;

    always_comb begin
        wsel = 32'(wbank_q);
        rsel = 32'(rbank_q);
    end

    assign waddr = {wbank_q, wp_q};
    assign raddr = {rbank_q, nxt_idx[IW-1:1]};
`else
    always_comb begin
        wsel = 0;
        rsel = 0;
    end

    assign waddr = wp_q;
    assign raddr = nxt_idx[IW-1:1];
`endif

    // -----------------------------------------------------------------------
    // Write side: next state per bank
    // -----------------------------------------------------------------------
    always_comb begin
        wr_fill = 1'b0;
        rd_full = 1'b0;
        for (int unsigned b = 0; b < NB; b++) begin
            if (b == wsel) wr_fill = (bank_q[b] == B_FILL);
            if (b == rsel) rd_full = (bank_q[b] == B_FULL);
        end

        wr_en      = word_stb && wr_fill;
        overflow_n = overflow | (word_stb & ~wr_fill);

        wp_n = wp_q;
`ifdef FFT_FRAME_PINGPONG_EN
        wbank_n = wbank_q;
`endif
        if (wr_en) begin
            if (wp_q == WP_LAST) begin
                wp_n = '0;
`ifdef FFT_FRAME_PINGPONG_EN
                wbank_n = ~wbank_q;
`endif
            end else begin
                wp_n = wp_q + WPW'(1);
            end
        end

        // A bank being written is in FILL and a bank being released is FULL,
        // so both updates can never target the same bank in one cycle.
        for (int unsigned b = 0; b < NB; b++) begin
            bank_n[b] = bank_q[b];
            if (wr_en && (wp_q == WP_LAST) && (b == wsel)) bank_n[b] = B_FULL;
            if (frame_release && (b == rsel))               bank_n[b] = B_FILL;
        end
    end

    // Word-wide storage; no reset needed, bank state says what is valid.
    logic [2*BIT_WIDTH-1:0] mem [NB*HALF];

    always_ff @(posedge clk) begin
        if (wr_en) mem[waddr] <= fft_in;
    end

    // -----------------------------------------------------------------------
    // Read side
    // -----------------------------------------------------------------------
    // Index of the sample to load next: 0 when starting a frame, otherwise
    // the successor of the one on the bus. Kept apart from the FSM so the
    // RAM read address does not depend on the FSM's own outputs.
    always_comb begin
        nxt_idx = '0;
        if (rs_q == R_STREAM) nxt_idx = idx_q + IW'(1);
    end

    assign rd_word = mem[raddr];

    always_comb begin
        rs_n          = rs_q;
        idx_n         = idx_q;
        so_n          = smp.sample_out;
        valid_n       = smp.sample_valid;
        last_n        = smp.sample_last;
        frame_release = 1'b0;

        unique case (rs_q)
            R_IDLE: begin
                if (rd_full) begin
                    rs_n    = R_STREAM;
                    idx_n   = nxt_idx;
                    valid_n = 1'b1;
                    last_n  = 1'b0;
                    so_n    = rd_word[2*BIT_WIDTH-1:BIT_WIDTH];
                end
            end
            R_STREAM: begin
                if (smp.sample_valid && smp.sample_ready) begin
                    if (idx_q == IDX_LAST) begin
                        // The idle cycle after the frame comes from passing
                        // through R_IDLE before the next bank is looked at.
                        rs_n          = R_IDLE;
                        valid_n       = 1'b0;
                        last_n        = 1'b0;
                        frame_release = 1'b1;
                    end else begin
                        idx_n   = nxt_idx;
                        valid_n = 1'b1;
                        last_n  = (nxt_idx == IDX_LAST);
                        so_n    = nxt_idx[0] ? rd_word[BIT_WIDTH-1:0]
                                             : rd_word[2*BIT_WIDTH-1:BIT_WIDTH];
                    end
                end
            end
            default: rs_n = R_IDLE;
        endcase
    end

`ifdef FFT_FRAME_PINGPONG_EN
    always_comb begin
        rbank_n = rbank_q ^ frame_release;
    end
`endif

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned b = 0; b < NB; b++) bank_q[b] <= B_FILL;
            wp_q             <= '0;
            rs_q             <= R_IDLE;
            idx_q            <= '0;
            smp.sample_out   <= '0;
            smp.sample_valid <= 1'b0;
            smp.sample_last  <= 1'b0;
            overflow         <= 1'b0;
            frames_done      <= '0;
`ifdef FFT_FRAME_PINGPONG_EN
            wbank_q          <= 1'b0;
            rbank_q          <= 1'b0;
`endif
        end else begin
            for (int unsigned b = 0; b < NB; b++) bank_q[b] <= bank_n[b];
            wp_q             <= wp_n;
            rs_q             <= rs_n;
            idx_q            <= idx_n;
            smp.sample_out   <= so_n;
            smp.sample_valid <= valid_n;
            smp.sample_last  <= last_n;
            overflow         <= overflow_n;
            if (frame_release) frames_done <= frames_done + 8'd1;
`ifdef FFT_FRAME_PINGPONG_EN
            wbank_q          <= wbank_n;
            rbank_q          <= rbank_n;
`endif
        end
    end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_buffer
//
// Drives SPI-style words into fft_frame_buffer and checks the sample stream
// against a frame-level reference model (word queue, bank occupancy count).
// Build with or without FFT_FRAME_PINGPONG_EN, matching the design build.
// ---------------------------------------------------------------------------
module tb_fft_frame_buffer;

    localparam int W    = 16;
    localparam int FL   = 64;
    localparam int HALF = FL / 2;
`ifdef FFT_FRAME_PINGPONG_EN
    localparam int NB   = 2;
`else
    localparam int NB   = 1;
`endif
    localparam int WORD_GAP = 40;    // clk cycles per received_wd phase
    localparam int DRAIN_MAX = 3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        received_wd;
    logic [31:0] fft_in;
    logic        overflow;
    logic [7:0]  frames_done;

    fft_frame_buffer_if #(.BIT_WIDTH(W)) smp ();

    fft_frame_buffer #(.BIT_WIDTH(W), .FRAME_LEN(FL)) dut (
        .clk         (clk),
        .reset       (reset),
        .received_wd (received_wd),
        .fft_in      (fft_in),
        .smp         (smp.master),
        .overflow    (overflow),
        .frames_done (frames_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         l;
        int           c;
    } smp_t;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    smp_t        exp_q [$];
    smp_t        got_q [$];
    logic [31:0] partial [$];
    int          occupied;
    int          frames_made;
    int          hs_count;
    logic        exp_ovf;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every handshake; each FL-th handshake frees one frame slot.
    always @(negedge clk) begin
        smp_t t;
        if (!reset && smp.sample_valid && smp.sample_ready) begin
            t.s = smp.sample_out;
            t.l = smp.sample_last;
            t.c = cyc;
            got_q.push_back(t);
            hs_count++;
            if (hs_count % FL == 0) occupied--;
        end
    end

    function automatic void model_reset();
        exp_q.delete();
        got_q.delete();
        partial.delete();
        occupied    = 0;
        frames_made = 0;
        hs_count    = 0;
        exp_ovf     = 1'b0;
    endfunction

    function automatic void model_word(input logic [31:0] w);
        smp_t t;
        if (occupied >= NB) begin
            exp_ovf = 1'b1;
        end else begin
            partial.push_back(w);
            if (partial.size() == HALF) begin
                for (int i = 0; i < HALF; i++) begin
                    t.c = 0;
                    t.s = partial[i][31:16]; t.l = 1'b0;             exp_q.push_back(t);
                    t.s = partial[i][15:0];  t.l = (i == HALF - 1);  exp_q.push_back(t);
                end
                partial.delete();
                occupied++;
                frames_made++;
            end
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic send_word(input logic [31:0] w);
        received_wd = 1'b0;
        repeat (WORD_GAP) @(negedge clk);
        fft_in      = w;
        received_wd = 1'b1;
        model_word(w);
        repeat (WORD_GAP) @(negedge clk);
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 smp.sample_ready = r;
    endtask

    task automatic wait_drain(output bit ok);
        int t = 0;
        while (got_q.size() < exp_q.size() && t < DRAIN_MAX) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        ok = (t < DRAIN_MAX);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        received_wd = 1'b1;
        fft_in      = 32'hDEAD_BEEF;
        smp.sample_ready = 1'b1;
        do_reset();
        repeat (20) @(negedge clk);
        checks++; if (smp.sample_out !== 16'h0) begin failures++; $display("FAIL reset_sample_out: got %h want 0000", smp.sample_out); end
        checks++; if (smp.sample_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", smp.sample_valid); end
        checks++; if (smp.sample_last !== 1'b0) begin failures++; $display("FAIL reset_last: got %b want 0", smp.sample_last); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (frames_done !== 8'd0) begin failures++; $display("FAIL reset_frames_done: got %0d want 0", frames_done); end
    endtask

    task automatic test_single_frame();
        bit ok;
        int gaps = 0;
        logic [31:0] w;
        set_ready(1'b1);
        for (int k = 0; k < HALF - 1; k++) begin
            w = {16'(2*k + 1), 16'(2*k + 2)};
            send_word(w);
        end
        // Last word driven by hand to check the word -> valid latency.
        received_wd = 1'b0;
        repeat (WORD_GAP) @(negedge clk);
        fft_in      = {16'(FL - 1), 16'(FL)};
        received_wd = 1'b1;
        model_word(fft_in);
        for (int k = 1; k <= WORD_GAP; k++) begin
            @(negedge clk);
            if (k == 4) begin
                checks++; if (smp.sample_valid !== 1'b0) begin failures++; $display("FAIL latency_early: got valid=%b want 0", smp.sample_valid); end
            end
            if (k == 5) begin
                checks++; if (smp.sample_valid !== 1'b1 || smp.sample_out !== 16'd1) begin
                    failures++; $display("FAIL latency_first: got valid=%b out=%0d want valid=1 out=1", smp.sample_valid, smp.sample_out);
                end
            end
        end
        wait_drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_drain: got %0d samples want %0d", got_q.size(), exp_q.size()); end
        checks++; if (got_q.size() !== FL) begin failures++; $display("FAIL single_count: got %0d want %0d", got_q.size(), FL); end
        for (int i = 0; i < got_q.size() && i < FL; i++) begin
            checks++;
            if (got_q[i].s !== 16'(i + 1) || got_q[i].l !== (i == FL - 1)) begin
                failures++; $display("FAIL single_sample[%0d]: got %0d last=%b want %0d last=%b", i, got_q[i].s, got_q[i].l, i + 1, (i == FL - 1));
            end
            if (i > 0 && got_q[i].c != got_q[i-1].c + 1) gaps++;
        end
        checks++; if (gaps !== 0) begin failures++; $display("FAIL single_bubbles: got %0d want 0", gaps); end
        checks++; if (frames_done !== 8'(frames_made)) begin failures++; $display("FAIL single_frames_done: got %0d want %0d", frames_done, frames_made); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure_toggle();
        bit ok;
        bit run = 1'b1;
        int bad_gap = 0;
        fork
            begin
                for (int k = 0; k < HALF; k++) send_word($urandom);
                wait_drain(ok);
                run = 1'b0;
            end
            begin
                while (run) begin
                    @(posedge clk);
                    #1 smp.sample_ready = ~smp.sample_ready;
                end
            end
            begin
                logic         stall = 1'b0;
                logic [W-1:0] prev_s = '0;
                logic         prev_l = 1'b0;
                while (run) begin
                    @(negedge clk);
                    if (stall) begin
                        checks++;
                        if (smp.sample_valid !== 1'b1 || smp.sample_out !== prev_s || smp.sample_last !== prev_l) begin
                            failures++; $display("FAIL hold: got v=%b out=%h last=%b want v=1 out=%h last=%b", smp.sample_valid, smp.sample_out, smp.sample_last, prev_s, prev_l);
                        end
                    end
                    stall  = smp.sample_valid && !smp.sample_ready;
                    prev_s = smp.sample_out;
                    prev_l = smp.sample_last;
                end
            end
        join
        set_ready(1'b1);
        checks++; if (!ok) begin failures++; $display("FAIL toggle_drain: got %0d samples want %0d", got_q.size(), exp_q.size()); end
        checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL toggle_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].s !== exp_q[i].s || got_q[i].l !== exp_q[i].l) begin
                failures++; $display("FAIL toggle_sample[%0d]: got %h last=%b want %h last=%b", i, got_q[i].s, got_q[i].l, exp_q[i].s, exp_q[i].l);
            end
            if (i > 0 && got_q[i].c != got_q[i-1].c + 2) bad_gap++;
        end
        checks++; if (bad_gap !== 0) begin failures++; $display("FAIL toggle_spacing: got %0d irregular gaps want 0", bad_gap); end
        checks++; if (frames_done !== 8'(frames_made)) begin failures++; $display("FAIL toggle_frames_done: got %0d want %0d", frames_done, frames_made); end
        got_q.delete(); exp_q.delete();
    endtask

`ifdef FFT_FRAME_PINGPONG_EN
    task automatic test_back_to_back();
        bit ok;
        int gaps = 0;
        set_ready(1'b0);
        for (int k = 0; k < 2 * HALF; k++) send_word($urandom);
        set_ready(1'b1);
        wait_drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_drain: got %0d samples want %0d", got_q.size(), exp_q.size()); end
        checks++; if (got_q.size() !== 2 * FL) begin failures++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), 2 * FL); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].s !== exp_q[i].s || got_q[i].l !== exp_q[i].l) begin
                failures++; $display("FAIL b2b_sample[%0d]: got %h last=%b want %h last=%b", i, got_q[i].s, got_q[i].l, exp_q[i].s, exp_q[i].l);
            end
            if (i > 0 && i != FL && got_q[i].c != got_q[i-1].c + 1) gaps++;
        end
        checks++; if (gaps !== 0) begin failures++; $display("FAIL b2b_bubbles: got %0d want 0", gaps); end
        if (got_q.size() > FL) begin
            checks++;
            if (got_q[FL].c - got_q[FL-1].c != 2) begin
                failures++; $display("FAIL b2b_idle_cycles: got %0d want 1", got_q[FL].c - got_q[FL-1].c - 1);
            end
        end
        checks++; if (frames_done !== 8'(frames_made)) begin failures++; $display("FAIL b2b_frames_done: got %0d want %0d", frames_done, frames_made); end
        got_q.delete(); exp_q.delete();
    endtask
`endif

    task automatic test_overflow();
        bit ok;
        set_ready(1'b0);
        for (int k = 0; k < NB * HALF; k++) send_word($urandom);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_before: got %b want 0", overflow); end
        send_word($urandom);
        checks++; if (overflow !== exp_ovf || exp_ovf !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b want %b", overflow, exp_ovf); end
        set_ready(1'b1);
        wait_drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL ovf_drain: got %0d samples want %0d", got_q.size(), exp_q.size()); end
        checks++; if (got_q.size() !== NB * FL) begin failures++; $display("FAIL ovf_count: got %0d want %0d", got_q.size(), NB * FL); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].s !== exp_q[i].s || got_q[i].l !== exp_q[i].l) begin
                failures++; $display("FAIL ovf_sample[%0d]: got %h last=%b want %h last=%b", i, got_q[i].s, got_q[i].l, exp_q[i].s, exp_q[i].l);
            end
        end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        checks++; if (frames_done !== 8'(frames_made)) begin failures++; $display("FAIL ovf_frames_done: got %0d want %0d", frames_done, frames_made); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        bit ok;
        set_ready(1'b1);
        for (int k = 0; k < 10; k++) send_word($urandom);
        do_reset();
        @(negedge clk);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL mid_reset_overflow: got %b want 0", overflow); end
        checks++; if (frames_done !== 8'd0) begin failures++; $display("FAIL mid_reset_frames_done: got %0d want 0", frames_done); end
        for (int k = 0; k < HALF; k++) send_word($urandom);
        wait_drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL mid_drain: got %0d samples want %0d", got_q.size(), exp_q.size()); end
        checks++; if (got_q.size() !== FL) begin failures++; $display("FAIL mid_count: got %0d want %0d", got_q.size(), FL); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].s !== exp_q[i].s || got_q[i].l !== exp_q[i].l) begin
                failures++; $display("FAIL mid_sample[%0d]: got %h last=%b want %h last=%b", i, got_q[i].s, got_q[i].l, exp_q[i].s, exp_q[i].l);
            end
        end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL mid_overflow: got %b want 0", overflow); end
        checks++; if (frames_done !== 8'd1) begin failures++; $display("FAIL mid_frames_done: got %0d want 1", frames_done); end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        reset            = 1'b1;
        received_wd      = 1'b1;
        fft_in           = '0;
        smp.sample_ready = 1'b0;
        model_reset();
        test_reset();
        test_single_frame();
        test_backpressure_toggle();
`ifdef FFT_FRAME_PINGPONG_EN
        test_back_to_back();
`endif
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
